// File: rtl/gremlin_dac_out_if.sv
// Register bus between the bus front-end and the gremlin palette DAC output stage.
// The front-end (master) issues single-cycle write/read strobes that are already in the pixel
// clock domain; the DAC (slave) returns registered read data.
interface gremlin_dac_out_if;
  logic       reg_wr;
  logic       reg_rd;
  logic [1:0] reg_addr;
  logic [7:0] reg_din;
  logic [7:0] reg_dout;

  modport master (
    output reg_wr,
    output reg_rd,
    output reg_addr,
    output reg_din,
    input  reg_dout
  );

  modport slave (
    input  reg_wr,
    input  reg_rd,
    input  reg_addr,
    input  reg_din,
    output reg_dout
  );
endinterface

// File: rtl/gremlin_dac_out.sv
// gremlin_dac_out: programmable palette DAC between the display core and the VGA pins.
// Pixel indices go through a 2-stage pipe (lookup, then blanking); syncs are delayed to match
// and polarity-adjusted. The palette is loaded as R, G, B byte triples through a data port.
// Optional build macro DAC_READBACK_EN adds a second palette read port so the data port can
// also be read back channel by channel; without it, data-port reads return zero.
module gremlin_dac_out #(
  parameter int IDX_W     = 4,
  parameter int RED_W     = 6,
  parameter int GREEN_W   = 7,
  parameter int BLUE_W    = 6,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic                clk,
  input  logic                busreset,
  gremlin_dac_out_if.slave    bus,
  input  logic [IDX_W-1:0]    pix_idx,
  input  logic                blank_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output logic [RED_W-1:0]    red,
  output logic [GREEN_W-1:0]  green,
  output logic [BLUE_W-1:0]   blue,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int PAL_W   = RED_W + GREEN_W + BLUE_W;

  typedef enum logic [1:0] {
    SUB_R = 2'd0,
    SUB_G = 2'd1,
    SUB_B = 2'd2
  } sub_t;

  // Palette entries are packed {R, G, B}, red in the MSBs.
  logic [PAL_W-1:0]   palette [ENTRIES];

  sub_t               wr_sub;
  sub_t               wr_sub_nxt;
  logic               commit;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [RED_W-1:0]   stage_r;
  logic [GREEN_W-1:0] stage_g;
  logic               pal_en;
  logic [7:0]         dout_q;

  logic               sel_wr_idx;
  logic               sel_data;
  logic               sel_rd_idx;
  logic               sel_ctrl;

  assign sel_wr_idx = bus.reg_wr && (bus.reg_addr == 2'd0);
  assign sel_data   = bus.reg_wr && (bus.reg_addr == 2'd1);
  assign sel_rd_idx = bus.reg_wr && (bus.reg_addr == 2'd2);
  assign sel_ctrl   = bus.reg_wr && (bus.reg_addr == 2'd3);

  // Replicates the pixel index MSB-first across a byte, giving the grey ramp used when the
  // palette is disabled; each channel then takes the top bits it needs.
  function automatic logic [7:0] grey_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] rep;
    rep = '0;
    for (int j = 0; j < 8; j++) begin
      rep[7-j] = idx[IDX_W-1-(j % IDX_W)];
    end
    return rep;
  endfunction

  // Write sequencer next state: an index write restarts at R, the B data write commits.
  always_comb begin
    wr_sub_nxt = wr_sub;
    commit     = 1'b0;
    if (sel_wr_idx) begin
      wr_sub_nxt = SUB_R;
    end else if (sel_data) begin
      case (wr_sub)
        SUB_R:   wr_sub_nxt = SUB_G;
        SUB_G:   wr_sub_nxt = SUB_B;
        default: begin
          wr_sub_nxt = SUB_R;
          commit     = 1'b1;
        end
      endcase
    end
  end

  // Write sequencer state register; reset discards any partially written triple.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      wr_sub <= SUB_R;
    end else begin
      wr_sub <= wr_sub_nxt;
    end
  end

  // Write index, R/G staging and control register.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      wr_idx  <= '0;
      stage_r <= '0;
      stage_g <= '0;
      pal_en  <= 1'b0;
    end else begin
      if (sel_wr_idx) begin
        wr_idx <= bus.reg_din[IDX_W-1:0];
      end else if (commit) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (sel_data && (wr_sub == SUB_R)) begin
        stage_r <= bus.reg_din[7 -: RED_W];
      end
      if (sel_data && (wr_sub == SUB_G)) begin
        stage_g <= bus.reg_din[7 -: GREEN_W];
      end
      if (sel_ctrl) begin
        pal_en <= bus.reg_din[0];
      end
    end
  end

  // Palette RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      palette[wr_idx] <= {stage_r, stage_g, bus.reg_din[7 -: BLUE_W]};
    end
  end

`ifdef DAC_READBACK_EN
  sub_t             rd_sub;
  logic [PAL_W-1:0] rb_entry;
  logic [7:0]       rb_byte;

  assign rb_entry = palette[rd_idx];

  // Selects the channel being read back and left-aligns it into a byte.
  always_comb begin
    rb_byte = 8'h00;
    case (rd_sub)
      SUB_R:   rb_byte = 8'(rb_entry[PAL_W-1 -: RED_W]) << (8 - RED_W);
      SUB_G:   rb_byte = 8'(rb_entry[BLUE_W +: GREEN_W]) << (8 - GREEN_W);
      default: rb_byte = 8'(rb_entry[BLUE_W-1:0]) << (8 - BLUE_W);
    endcase
  end
`endif

  // Register reads and the read index; a same-cycle write wins over a read-side update.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      dout_q <= 8'h00;
      rd_idx <= '0;
`ifdef DAC_READBACK_EN
      rd_sub <= SUB_R;
`endif
    end else begin
      if (bus.reg_rd) begin
        case (bus.reg_addr)
          2'd0: dout_q <= 8'(wr_idx);
          2'd1: begin
`ifdef DAC_READBACK_EN
            dout_q <= rb_byte;
            case (rd_sub)
              SUB_R:   rd_sub <= SUB_G;
              SUB_G:   rd_sub <= SUB_B;
              default: begin
                rd_sub <= SUB_R;
                rd_idx <= rd_idx + 1'b1;
              end
            endcase
`else
            dout_q <= 8'h00;
`endif
          end
          2'd2:    dout_q <= 8'(rd_idx);
          default: dout_q <= {7'b0, pal_en};
        endcase
      end
      if (sel_rd_idx) begin
        rd_idx <= bus.reg_din[IDX_W-1:0];
`ifdef DAC_READBACK_EN
        rd_sub <= SUB_R;
`endif
      end
    end
  end

  assign bus.reg_dout = dout_q;

  logic [PAL_W-1:0]   lookup;
  logic [7:0]         grey;
  logic [RED_W-1:0]   s1_r;
  logic [GREEN_W-1:0] s1_g;
  logic [BLUE_W-1:0]  s1_b;
  logic               s1_blank;
  logic               s1_hs;
  logic               s1_vs;

  assign lookup = palette[pix_idx];
  assign grey   = grey_byte(pix_idx);

  // Pixel stage 1: palette lookup or grey ramp, registered with blank and syncs.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_blank <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
    end else begin
      if (pal_en) begin
        s1_r <= lookup[PAL_W-1 -: RED_W];
        s1_g <= lookup[BLUE_W +: GREEN_W];
        s1_b <= lookup[BLUE_W-1:0];
      end else begin
        s1_r <= grey[7 -: RED_W];
        s1_g <= grey[7 -: GREEN_W];
        s1_b <= grey[7 -: BLUE_W];
      end
      s1_blank <= blank_in;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
    end
  end

  // Pixel stage 2: blanking forces black, syncs take their output polarity.
  always_ff @(posedge clk or posedge busreset) begin
    if (busreset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync_out <= ~HSYNC_POL;
      vsync_out <= ~VSYNC_POL;
    end else begin
      red       <= s1_blank ? '0 : s1_r;
      green     <= s1_blank ? '0 : s1_g;
      blue      <= s1_blank ? '0 : s1_b;
      hsync_out <= s1_hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_out <= s1_vs ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: tb/tb_gremlin_dac_out.sv
// Self-checking bench for gremlin_dac_out. hsync uses active-low output polarity so both
// polarities are exercised. A byte-level palette model predicts pixels and read data.
module tb_gremlin_dac_out;
  localparam int IDX_W   = 4;
  localparam int RED_W   = 6;
  localparam int GREEN_W = 7;
  localparam int BLUE_W  = 6;
  localparam bit HS_POL  = 1'b0;
  localparam bit VS_POL  = 1'b1;
`ifdef DAC_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               busreset;
  logic [IDX_W-1:0]   pix_idx;
  logic               blank_in;
  logic               hsync_in;
  logic               vsync_in;
  logic [RED_W-1:0]   red;
  logic [GREEN_W-1:0] green;
  logic [BLUE_W-1:0]  blue;
  logic               hsync_out;
  logic               vsync_out;

  gremlin_dac_out_if bus_if ();

  gremlin_dac_out #(
    .IDX_W(IDX_W), .RED_W(RED_W), .GREEN_W(GREEN_W), .BLUE_W(BLUE_W),
    .HSYNC_POL(HS_POL), .VSYNC_POL(VS_POL)
  ) dut (
    .clk(clk), .busreset(busreset), .bus(bus_if),
    .pix_idx(pix_idx), .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red), .green(green), .blue(blue), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: palette held as the bytes a reader would see (low bits dropped).
  logic [7:0]         m_pal [16][3];
  logic [7:0]         m_stage [2];
  logic [3:0]         m_wr_idx;
  logic [3:0]         m_rd_idx;
  int                 m_wr_sub;
  int                 m_rd_sub;
  logic               m_pal_en;
  logic [7:0]         exp_dout;
  logic [RED_W-1:0]   exp_r, last_r;
  logic [GREEN_W-1:0] exp_g, last_g;
  logic [BLUE_W-1:0]  exp_b, last_b;
  logic               exp_hs, last_hs, exp_vs, last_vs;

  task automatic model_reset();
    m_wr_idx = '0; m_rd_idx = '0; m_wr_sub = 0; m_rd_sub = 0; m_pal_en = 1'b0;
    exp_dout = 8'h00;
    last_r = '0; last_g = '0; last_b = '0; last_hs = !HS_POL; last_vs = !VS_POL;
    exp_r = last_r; exp_g = last_g; exp_b = last_b; exp_hs = last_hs; exp_vs = last_vs;
  endtask

  // Advances model and DUT by one clock using the inputs currently applied.
  task automatic tick();
    logic [7:0] rb, gb, bb;
    if (m_pal_en) begin
      rb = m_pal[pix_idx][0]; gb = m_pal[pix_idx][1]; bb = m_pal[pix_idx][2];
    end else begin
      rb = {pix_idx, pix_idx}; gb = rb; bb = rb;
    end
    if (blank_in) begin
      rb = 8'h00; gb = 8'h00; bb = 8'h00;
    end
    exp_r = last_r; exp_g = last_g; exp_b = last_b; exp_hs = last_hs; exp_vs = last_vs;
    last_r  = RED_W'(rb >> (8 - RED_W));
    last_g  = GREEN_W'(gb >> (8 - GREEN_W));
    last_b  = BLUE_W'(bb >> (8 - BLUE_W));
    last_hs = hsync_in ? HS_POL : !HS_POL;
    last_vs = vsync_in ? VS_POL : !VS_POL;
    if (bus_if.reg_rd) begin
      case (bus_if.reg_addr)
        2'd0: exp_dout = {4'h0, m_wr_idx};
        2'd1: begin
          if (READBACK) begin
            exp_dout = m_pal[m_rd_idx][m_rd_sub];
            if (m_rd_sub == 2) begin
              m_rd_sub = 0;
              m_rd_idx = m_rd_idx + 4'd1;
            end else begin
              m_rd_sub++;
            end
          end else begin
            exp_dout = 8'h00;
          end
        end
        2'd2: exp_dout = {4'h0, m_rd_idx};
        default: exp_dout = {7'h00, m_pal_en};
      endcase
    end
    if (bus_if.reg_wr) begin
      case (bus_if.reg_addr)
        2'd0: begin m_wr_idx = bus_if.reg_din[3:0]; m_wr_sub = 0; end
        2'd1: begin
          if (m_wr_sub < 2) begin
            m_stage[m_wr_sub] = bus_if.reg_din;
            m_wr_sub++;
          end else begin
            m_pal[m_wr_idx][0] = m_stage[0] & (8'hFF << (8 - RED_W));
            m_pal[m_wr_idx][1] = m_stage[1] & (8'hFF << (8 - GREEN_W));
            m_pal[m_wr_idx][2] = bus_if.reg_din & (8'hFF << (8 - BLUE_W));
            m_wr_idx = m_wr_idx + 4'd1;
            m_wr_sub = 0;
          end
        end
        2'd2: begin m_rd_idx = bus_if.reg_din[3:0]; m_rd_sub = 0; end
        default: m_pal_en = bus_if.reg_din[0];
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic wr, input logic rd, input logic [1:0] addr,
                        input logic [7:0] din);
    bus_if.reg_wr = wr; bus_if.reg_rd = rd; bus_if.reg_addr = addr; bus_if.reg_din = din;
    tick();
    bus_if.reg_wr = 1'b0; bus_if.reg_rd = 1'b0;
  endtask

  task automatic random_pixel();
    pix_idx  = 4'($urandom);
    blank_in = ($urandom_range(0, 3) == 0);
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
  endtask

  task automatic test_reset();
    busreset = 1'b1;
    pix_idx = 4'hF; blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({red, green, blue} !== 19'd0) begin
      n_errors++; $display("[TB] FAIL reset_rgb: got %h/%h/%h want 0", red, green, blue);
    end
    n_checks++;
    if (hsync_out !== !HS_POL || vsync_out !== !VS_POL) begin
      n_errors++; $display("[TB] FAIL reset_sync: got hs=%b vs=%b want %b %b",
                           hsync_out, vsync_out, !HS_POL, !VS_POL);
    end
    n_checks++;
    if (bus_if.reg_dout !== 8'h00) begin
      n_errors++; $display("[TB] FAIL reset_dout: got %h want 00", bus_if.reg_dout);
    end
    busreset = 1'b0;
    model_reset();
    tick();
    tick();
    n_checks++;
    if (red !== 6'h3F || green !== 7'h7F || blue !== 6'h3F) begin
      n_errors++; $display("[TB] FAIL grey_full: got %h/%h/%h want 3f/7f/3f", red, green, blue);
    end
  endtask

  task automatic test_program();
    bus_op(1'b1, 1'b0, 2'd0, 8'h00);
    for (int i = 0; i < 48; i++) begin
      random_pixel();
      bus_op(1'b1, 1'b0, 2'd1, 8'($urandom));
      n_checks++;
      if ({red, green, blue, hsync_out, vsync_out} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
        n_errors++; $display("[TB] FAIL grey_pixel: got %h/%h/%h %b%b want %h/%h/%h %b%b",
          red, green, blue, hsync_out, vsync_out, exp_r, exp_g, exp_b, exp_hs, exp_vs);
      end
    end
    bus_op(1'b1, 1'b0, 2'd0, 8'd5);
    bus_op(1'b1, 1'b0, 2'd1, 8'hFC);
    bus_op(1'b1, 1'b0, 2'd1, 8'h80);
    bus_op(1'b1, 1'b0, 2'd1, 8'h04);
    bus_op(1'b1, 1'b0, 2'd3, 8'h01);
    pix_idx = 4'd5; blank_in = 1'b0;
    tick();
    tick();
    n_checks++;
    if (red !== 6'h3F || green !== 7'h40 || blue !== 6'h01) begin
      n_errors++; $display("[TB] FAIL entry5: got %h/%h/%h want 3f/40/01", red, green, blue);
    end
    for (int i = 0; i < 3; i++) bus_op(1'b1, 1'b0, 2'd1, 8'($urandom));
    bus_op(1'b0, 1'b1, 2'd0, 8'h00);
    n_checks++;
    if (bus_if.reg_dout !== 8'h07) begin
      n_errors++; $display("[TB] FAIL wr_idx_after6: got %h want 07", bus_if.reg_dout);
    end
  endtask

  task automatic test_wrap();
    bus_op(1'b1, 1'b0, 2'd0, 8'd15);
    for (int i = 0; i < 3; i++) bus_op(1'b1, 1'b0, 2'd1, 8'($urandom));
    bus_op(1'b0, 1'b1, 2'd0, 8'h00);
    n_checks++;
    if (bus_if.reg_dout !== 8'h00) begin
      n_errors++; $display("[TB] FAIL wr_idx_wrap: got %h want 00", bus_if.reg_dout);
    end
  endtask

  task automatic test_readback();
    logic [7:0] want [3];
    want[0] = READBACK ? 8'hFC : 8'h00;
    want[1] = READBACK ? 8'h80 : 8'h00;
    want[2] = READBACK ? 8'h04 : 8'h00;
    bus_op(1'b1, 1'b0, 2'd2, 8'd5);
    for (int i = 0; i < 3; i++) begin
      bus_op(1'b0, 1'b1, 2'd1, 8'h00);
      n_checks++;
      if (bus_if.reg_dout !== want[i]) begin
        n_errors++; $display("[TB] FAIL readback%0d: got %h want %h", i, bus_if.reg_dout, want[i]);
      end
    end
    bus_op(1'b0, 1'b1, 2'd2, 8'h00);
    n_checks++;
    if (bus_if.reg_dout !== (READBACK ? 8'h06 : 8'h05)) begin
      n_errors++; $display("[TB] FAIL rd_idx_after: got %h want %h", bus_if.reg_dout,
                           READBACK ? 8'h06 : 8'h05);
    end
  endtask

  task automatic test_sync_blank();
    for (int i = 0; i < 60; i++) begin
      random_pixel();
      hsync_in = (i % 7) < 2;
      tick();
      n_checks++;
      if ({red, green, blue, hsync_out, vsync_out} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
        n_errors++; $display("[TB] FAIL sync_blank: got %h/%h/%h %b%b want %h/%h/%h %b%b",
          red, green, blue, hsync_out, vsync_out, exp_r, exp_g, exp_b, exp_hs, exp_vs);
      end
    end
  endtask

  task automatic test_collision();
    logic [3:0] n;
    n = 4'($urandom);
    bus_op(1'b1, 1'b0, 2'd3, 8'h01);
    bus_op(1'b1, 1'b0, 2'd0, {4'h0, n});
    bus_op(1'b1, 1'b0, 2'd1, ~m_pal[n][0]);
    bus_op(1'b1, 1'b0, 2'd1, ~m_pal[n][1]);
    pix_idx = n; blank_in = 1'b0;
    bus_op(1'b1, 1'b0, 2'd1, ~m_pal[n][2]);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_checks++;
      if ({red, green, blue} !== {exp_r, exp_g, exp_b}) begin
        n_errors++; $display("[TB] FAIL collision%0d: got %h/%h/%h want %h/%h/%h",
          i, red, green, blue, exp_r, exp_g, exp_b);
      end
    end
  endtask

  task automatic test_reset_midseq();
    bus_op(1'b1, 1'b0, 2'd0, 8'd9);
    bus_op(1'b1, 1'b0, 2'd1, ~m_pal[9][0]);
    bus_op(1'b1, 1'b0, 2'd1, ~m_pal[9][1]);
    busreset = 1'b1;
    @(posedge clk);
    #1;
    busreset = 1'b0;
    model_reset();
    bus_op(1'b1, 1'b0, 2'd3, 8'h01);
    bus_op(1'b1, 1'b0, 2'd1, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      pix_idx = (i < 4) ? 4'd9 : 4'd0;
      blank_in = 1'b0;
      if (i == 4) bus_op(1'b1, 1'b0, 2'd1, 8'($urandom));
      else if (i == 5) bus_op(1'b1, 1'b0, 2'd1, 8'($urandom));
      else tick();
      n_checks++;
      if ({red, green, blue} !== {exp_r, exp_g, exp_b}) begin
        n_errors++; $display("[TB] FAIL midseq%0d: got %h/%h/%h want %h/%h/%h",
          i, red, green, blue, exp_r, exp_g, exp_b);
      end
    end
    bus_op(1'b0, 1'b1, 2'd0, 8'h00);
    n_checks++;
    if (bus_if.reg_dout !== 8'h01) begin
      n_errors++; $display("[TB] FAIL midseq_wr_idx: got %h want 01", bus_if.reg_dout);
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      random_pixel();
      bus_op(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      n_checks++;
      if ({red, green, blue, hsync_out, vsync_out} !== {exp_r, exp_g, exp_b, exp_hs, exp_vs}) begin
        n_errors++; $display("[TB] FAIL rand_pixel%0d: got %h/%h/%h %b%b want %h/%h/%h %b%b",
          i, red, green, blue, hsync_out, vsync_out, exp_r, exp_g, exp_b, exp_hs, exp_vs);
      end
      n_checks++;
      if (bus_if.reg_dout !== exp_dout) begin
        n_errors++; $display("[TB] FAIL rand_dout%0d: got %h want %h", i, bus_if.reg_dout, exp_dout);
      end
    end
  endtask

  initial begin
    busreset = 1'b1;
    bus_if.reg_wr = 1'b0; bus_if.reg_rd = 1'b0; bus_if.reg_addr = 2'd0; bus_if.reg_din = 8'h00;
    pix_idx = '0; blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    model_reset();
    test_reset();
    test_program();
    test_wrap();
    test_readback();
    test_sync_blank();
    test_collision();
    test_reset_midseq();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
